// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit/receive pair: state encodings, parity
// selectors and default widths.
package uart_pkg;

  localparam int DATA_W = 8;
  localparam int PRE_W  = 6;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_STOP2  = 3'd5;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tc is high while the count sits at zero, so a bit loaded
// with N-1 expires after exactly N clocks.
module uart_bit_timer #(
  parameter int PRE_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [PRE_W-1:0] load_val,
  output logic             tc
);

  logic [PRE_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - PRE_W'(1);
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, W data bits LSB first, optional parity, stop bit(s).
// Define UART_TX_STOP2_EN to add the STOP2 port for an optional second stop bit.
module uart_tx_frame #(
  parameter int W     = uart_pkg::DATA_W,
  parameter int PRE_W = uart_pkg::PRE_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [PRE_W-1:0] PRESCALE,
  input  logic             PER_EN,
  input  logic             PAR_TYP,
  input  logic [W-1:0]     P_DATA,
`ifdef UART_TX_STOP2_EN
  input  logic             STOP2,
`endif
  input  logic             DATA_VALID,
  output logic             TX_OUT,
  output logic             BUSY
);
  import uart_pkg::*;

  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  logic [2:0]       state_q, state_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [PRE_W-1:0] pre_q;
  logic             per_en_q, par_bit_q;
  logic             accept, tc, load;
  logic [PRE_W-1:0] load_val;

  assign accept   = (state_q == ST_IDLE) && DATA_VALID;
  assign load     = accept || ((state_q != ST_IDLE) && tc);
  // PRESCALE of 0 wraps to all-ones, giving 2**PRE_W clocks per bit.
  assign load_val = (accept ? PRESCALE : pre_q) - PRE_W'(1);

  uart_bit_timer #(
    .PRE_W(PRE_W)
  ) u_bit_timer (
    .clk     (CLK),
    .rst_n   (RST),
    .load    (load),
    .load_val(load_val),
    .tc      (tc)
  );

`ifdef UART_TX_STOP2_EN
  logic stop2_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stop2_q <= 1'b0;
    end else if (accept) begin
      stop2_q <= STOP2;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    if (accept) begin
      state_d = ST_START;
      shreg_d = P_DATA;
      idx_d   = '0;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end else if ((state_q != ST_IDLE) && tc) begin
      case (state_q)
        ST_START: begin
          state_d = ST_DATA;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
        ST_DATA: begin
          if (idx_q == IDX_W'(W - 1)) begin
            state_d = per_en_q ? ST_PARITY : ST_STOP;
            tx_d    = per_en_q ? par_bit_q : 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
        ST_PARITY: begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
        ST_STOP: begin
`ifdef UART_TX_STOP2_EN
          if (stop2_q) begin
            state_d = ST_STOP2;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
`else
          state_d = ST_IDLE;
          busy_d  = 1'b0;
`endif
        end
        default: begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      pre_q     <= '0;
      per_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      if (accept) begin
        pre_q     <= PRESCALE;
        per_en_q  <= PER_EN;
        par_bit_q <= (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
      end
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: a table of frames plus hand-written
// back-to-back, ignored-strobe, mid-frame reset and long-prescale sequences.
module tb_uart_tx_frame;

  logic       CLK;
  logic       RST;
  logic [5:0] PRESCALE;
  logic       PER_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       TX_OUT;
  logic       BUSY;
`ifdef UART_TX_STOP2_EN
  logic       STOP2;
`endif

  uart_tx_frame dut (
    .CLK       (CLK),
    .RST       (RST),
    .PRESCALE  (PRESCALE),
    .PER_EN    (PER_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
`ifdef UART_TX_STOP2_EN
    .STOP2     (STOP2),
`endif
    .DATA_VALID(DATA_VALID),
    .TX_OUT    (TX_OUT),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0] pre;
    logic       per_en;
    logic       par_typ;
    logic [7:0] data;
    logic       exp_par;
    int         bit_clk;
    int         exp_len;
  } vec_t;

  typedef struct {
    logic [11:0] bits;
    int          bit_clk;
    int          exp_len;
    logic        b2b;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  vec_t vecs[6];

  int n_cmp = 0;
  int n_err = 0;
  int frames_done = 0;
  int target = 0;
  int cnt = 0;
  int idle = 0;
  bit active = 0;
  bit unexp = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Expected line levels, index 0 = start bit; unused high slots model stop/idle.
  function automatic logic [11:0] mk_bits(input logic [7:0] d, input logic per,
                                          input logic p);
    logic [11:0] b;
    b      = 12'hFFF;
    b[0]   = 1'b0;
    b[8:1] = d;
    if (per) b[9] = p;
    return b;
  endfunction

  // Frame monitor: pops the expected frame when BUSY rises, checks every clock.
  always @(negedge CLK) begin
    if (!RST) begin
      active = 0;
      idle   = 0;
    end else begin
      if (!active && BUSY) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_frame: got a frame, expected none (t=%0t)", $time);
          unexp = 1;
        end else begin
          cur   = sb.pop_front();
          unexp = 0;
          if (cur.b2b) chk("b2b_gap_clocks", idle, 1);
        end
        active = 1;
        cnt    = 0;
      end
      if (active) begin
        if (BUSY) begin
          if (!unexp) begin
            if (cnt < cur.exp_len) chk("tx_bit", TX_OUT, cur.bits[cnt / cur.bit_clk]);
            else if (cnt == cur.exp_len) chk("busy_overrun", 1, 0);
          end
          cnt++;
        end else begin
          if (!unexp) begin
            chk("frame_len", cnt, cur.exp_len);
            chk("idle_line", TX_OUT, 1);
          end
          active = 0;
          idle   = 1;
          frames_done++;
        end
      end else if (!BUSY) begin
        idle++;
      end
    end
  end

  task automatic send(input logic [5:0] pre, input logic per, input logic par,
                      input logic [7:0] d, input logic [11:0] bits, input int bit_clk,
                      input int exp_len);
    exp_t e;
    @(negedge CLK);
    PRESCALE   = pre;
    PER_EN     = per;
    PAR_TYP    = par;
    P_DATA     = d;
    DATA_VALID = 1'b1;
    e.bits = bits; e.bit_clk = bit_clk; e.exp_len = exp_len; e.b2b = 1'b0;
    sb.push_back(e);
    @(negedge CLK);
    DATA_VALID = 1'b0;
  endtask

  task automatic wait_frames(input int tgt);
    for (int i = 0; i < 2000 && frames_done < tgt; i++) @(negedge CLK);
    #1;
    chk("frames_done", frames_done, tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vecs[0] = '{6'd16, 1'b1, 1'b1, 8'hA5, 1'b1, 16, 176};
    vecs[1] = '{6'd4,  1'b1, 1'b0, 8'h07, 1'b1, 4,  44};
    vecs[2] = '{6'd8,  1'b0, 1'b0, 8'h3C, 1'b0, 8,  80};
    vecs[3] = '{6'd1,  1'b1, 1'b0, 8'hFF, 1'b0, 1,  11};
    vecs[4] = '{6'd3,  1'b1, 1'b1, 8'h00, 1'b1, 3,  33};
    vecs[5] = '{6'd0,  1'b0, 1'b0, 8'h5A, 1'b0, 64, 640};

    RST = 1'b1; PRESCALE = '0; PER_EN = 0; PAR_TYP = 0; P_DATA = '0; DATA_VALID = 0;
`ifdef UART_TX_STOP2_EN
    STOP2 = 1'b0;
`endif
    #1 RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_tx", TX_OUT, 1);
    chk("reset_busy", BUSY, 0);
    #2 RST = 1'b1;

    foreach (vecs[k]) begin
      send(vecs[k].pre, vecs[k].per_en, vecs[k].par_typ, vecs[k].data,
           mk_bits(vecs[k].data, vecs[k].per_en, vecs[k].exp_par),
           vecs[k].bit_clk, vecs[k].exp_len);
      target++;
      wait_frames(target);
    end

    // A strobe mid-frame must be dropped without disturbing the frame.
    send(6'd8, 1'b0, 1'b0, 8'h3C, mk_bits(8'h3C, 1'b0, 1'b0), 8, 80);
    repeat (20) @(negedge CLK);
    P_DATA = 8'h99; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    target++;
    wait_frames(target);
    repeat (5) @(negedge CLK);

    // Held strobe: second byte and new settings presented while busy.
    @(negedge CLK);
    PRESCALE = 6'd4; PER_EN = 1'b1; PAR_TYP = 1'b1; P_DATA = 8'h11; DATA_VALID = 1'b1;
    e.bits = mk_bits(8'h11, 1'b1, 1'b1); e.bit_clk = 4; e.exp_len = 44; e.b2b = 1'b0;
    sb.push_back(e);
    @(negedge CLK);
    PRESCALE = 6'd6; PER_EN = 1'b0; PAR_TYP = 1'b0; P_DATA = 8'h22;
    e.bits = mk_bits(8'h22, 1'b0, 1'b0); e.bit_clk = 6; e.exp_len = 60; e.b2b = 1'b1;
    sb.push_back(e);
    for (int i = 0; i < 100 && BUSY; i++) @(negedge CLK);
    for (int i = 0; i < 5 && !BUSY; i++) @(negedge CLK);
    DATA_VALID = 1'b0;
    target += 2;
    wait_frames(target);

    // Reset at clock 40 of a frame, while a data bit of 0 is on the line.
    send(6'd16, 1'b1, 1'b1, 8'hA5, mk_bits(8'hA5, 1'b1, 1'b1), 16, 176);
    repeat (39) @(negedge CLK);
    chk("pre_reset_tx", TX_OUT, 0);
    #2 RST = 1'b0;
    #1;
    chk("async_reset_tx", TX_OUT, 1);
    chk("async_reset_busy", BUSY, 0);
    @(negedge CLK);
    #2 RST = 1'b1;
    send(6'd16, 1'b1, 1'b0, 8'h3C, mk_bits(8'h3C, 1'b1, 1'b0), 16, 176);
    target++;
    wait_frames(target);

`ifdef UART_TX_STOP2_EN
    STOP2 = 1'b1;
    send(6'd0, 1'b1, 1'b1, 8'h5A, mk_bits(8'h5A, 1'b1, 1'b1), 64, 768);
    STOP2 = 1'b0;
    target++;
    wait_frames(target);
`endif

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
